// File: rtl/pixel_stream_pkg.sv
// Shared types and constants for the pixel stream buffer: FIFO entry layout,
// output framing states, the RGB332 palette and the pointer-width helper.
package pixel_stream_pkg;

    localparam int DATA_WIDTH = 4;
    localparam int OUT_WIDTH  = 2 * DATA_WIDTH;

    typedef struct packed {
        logic [OUT_WIDTH-1:0] data;
        logic                 sop;
        logic                 eop;
    } fifo_entry_t;

    typedef enum logic {
        OUT_IDLE = 1'b0,
        OUT_PKT  = 1'b1
    } framing_state_t;

    // 16-colour table in RGB332 (RRRGGGBB), EGA-like ordering.
    localparam logic [7:0] PALETTE [16] = '{
        8'h00, 8'h02, 8'h10, 8'h12,
        8'h80, 8'h82, 8'h90, 8'hB6,
        8'h49, 8'h03, 8'h1C, 8'h1F,
        8'hE0, 8'hE3, 8'hFC, 8'hFF
    };

    // One extra bit beyond the index so full and empty can be told apart.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pixel_stream_buffer_if.sv
// Request side (iterator/solver) and Avalon-ST video source side of the
// pixel stream buffer, bundled with slave (buffer) and master (driver) views.
interface pixel_stream_buffer_if;
    import pixel_stream_pkg::*;

    logic                  in_valid;
    logic                  in_start;
    logic                  in_end;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_start;
    logic                  out_end;
    logic [OUT_WIDTH-1:0]  out_data;
    logic                  framing_err;

    modport slave (
        input  in_valid, in_start, in_end, rd_data, out_ready,
        output in_ready, out_valid, out_start, out_end, out_data, framing_err
    );

    modport master (
        output in_valid, in_start, in_end, rd_data, out_ready,
        input  in_ready, out_valid, out_start, out_end, out_data, framing_err
    );

endinterface

// File: rtl/pixel_stream_fifo.sv
// Show-ahead synchronous FIFO: head always presents the oldest entry, count
// reports occupancy. A push together with a pop is accepted even when full.
module pixel_stream_fifo
    import pixel_stream_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int IDX_W = PTR_W - 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_next;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[PTR_W-1] != rd_ptr_reg[PTR_W-1]) &&
                   (wr_ptr_reg[IDX_W-1:0] == rd_ptr_reg[IDX_W-1:0]);

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_next = wr_ptr_reg + PTR_W'(do_push);
        rd_ptr_next = rd_ptr_reg + PTR_W'(do_pop);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
        end
    end

    // Storage carries no reset; stale contents are never visible because the
    // consumer gates everything with empty.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr_reg[IDX_W-1:0]] <= push_data;
        end
    end

    assign head  = mem[rd_ptr_reg[IDX_W-1:0]];
    assign count = wr_ptr_reg - rd_ptr_reg;

endmodule

// File: rtl/pixel_stream_buffer.sv
// Tracks pixel requests through the solver read latency, buffers the results
// and drives a credit-backpressured Avalon-ST video source. PIXEL_PALETTE_EN
// replaces nibble duplication with a PALETTE lookup at FIFO push.
module pixel_stream_buffer
    import pixel_stream_pkg::*;
#(
    parameter int READ_LATENCY = 2,
    parameter int DEPTH        = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    pixel_stream_buffer_if.slave bus
);

    localparam int CNT_W = ptr_w(DEPTH);

    logic                    accept;
    logic                    in_ready;
    logic                    pop;
    logic                    empty;
    logic                    exit_valid;
    logic [CNT_W-1:0]        fifo_count;
    logic [CNT_W-1:0]        inflight_count_reg;
    logic [CNT_W-1:0]        inflight_count_next;
    logic [CNT_W:0]          outstanding;
    logic [READ_LATENCY-1:0] pipe_valid_reg;
    logic [READ_LATENCY-1:0] pipe_start_reg;
    logic [READ_LATENCY-1:0] pipe_end_reg;
    fifo_entry_t             push_entry;
    fifo_entry_t             head_entry;
    framing_state_t          state_reg;
    framing_state_t          state_next;
    logic                    err_reg;
    logic                    err_next;

    // Credits: every accepted pixel owns a FIFO slot from acceptance until pop,
    // so a push can never meet a full FIFO. Only registered counters feed this.
    assign outstanding = {1'b0, inflight_count_reg} + {1'b0, fifo_count};
    assign in_ready    = (outstanding < (CNT_W+1)'(DEPTH));
    assign accept      = bus.in_valid && in_ready;
    assign bus.in_ready = in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < READ_LATENCY; gi++) begin : g_pipe
            if (gi == 0) begin : g_first
                always_ff @(posedge clock or posedge reset) begin
                    if (reset) begin
                        pipe_valid_reg[gi] <= 1'b0;
                        pipe_start_reg[gi] <= 1'b0;
                        pipe_end_reg[gi]   <= 1'b0;
                    end else begin
                        pipe_valid_reg[gi] <= accept;
                        pipe_start_reg[gi] <= accept && bus.in_start;
                        pipe_end_reg[gi]   <= accept && bus.in_end;
                    end
                end
            end else begin : g_rest
                always_ff @(posedge clock or posedge reset) begin
                    if (reset) begin
                        pipe_valid_reg[gi] <= 1'b0;
                        pipe_start_reg[gi] <= 1'b0;
                        pipe_end_reg[gi]   <= 1'b0;
                    end else begin
                        pipe_valid_reg[gi] <= pipe_valid_reg[gi-1];
                        pipe_start_reg[gi] <= pipe_start_reg[gi-1];
                        pipe_end_reg[gi]   <= pipe_end_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign exit_valid = pipe_valid_reg[READ_LATENCY-1];

    always_comb begin
        inflight_count_next = inflight_count_reg + CNT_W'(accept) - CNT_W'(exit_valid);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inflight_count_reg <= '0;
        end else begin
            inflight_count_reg <= inflight_count_next;
        end
    end

    // Solver data is only meaningful while the pipe exit is valid; it is
    // captured that same cycle.
    always_comb begin
        push_entry = '0;
`ifdef PIXEL_PALETTE_EN
        push_entry.data = PALETTE[bus.rd_data];
`else
        push_entry.data = {bus.rd_data, bus.rd_data};
`endif
        push_entry.sop = pipe_start_reg[READ_LATENCY-1];
        push_entry.eop = pipe_end_reg[READ_LATENCY-1];
    end

    pixel_stream_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fifo_entry_t))
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (exit_valid),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head_entry),
        .empty     (empty),
        .count     (fifo_count)
    );

    assign pop           = !empty && bus.out_ready;
    assign bus.out_valid = !empty;
    assign bus.out_data  = empty ? '0 : head_entry.data;
    assign bus.out_start = !empty && head_entry.sop;
    assign bus.out_end   = !empty && head_entry.eop;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= OUT_IDLE;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            err_reg   <= err_next;
        end
    end

    // Framing advances only on beats the sink actually takes.
    always_comb begin
        state_next = state_reg;
        err_next   = err_reg;
        if (pop) begin
            case (state_reg)
                OUT_IDLE: begin
                    if (!head_entry.sop) begin
                        err_next = 1'b1;
                    end else if (!head_entry.eop) begin
                        state_next = OUT_PKT;
                    end
                end
                OUT_PKT: begin
                    if (head_entry.sop) begin
                        err_next = 1'b1;
                    end
                    if (head_entry.eop) begin
                        state_next = OUT_IDLE;
                    end
                end
                default: state_next = OUT_IDLE;
            endcase
        end
    end

    assign bus.framing_err = err_reg;

endmodule

// File: tb/tb_pixel_stream_buffer.sv
// Directed bench for pixel_stream_buffer: timing, backpressure, random-ready
// frame, framing error and mid-frame reset; PIXEL_PALETTE_EN selects expected mapping.
module tb_pixel_stream_buffer;
    import pixel_stream_pkg::*;

    localparam int RL    = 2;
    localparam int DEPTH = 8;
    localparam int FRAME_W = 64;
    localparam int FRAME_H = 48;
    localparam int NPIX  = FRAME_W * FRAME_H;
    localparam int LIMIT = 20000;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    pixel_stream_buffer_if bus();

    pixel_stream_buffer #(
        .READ_LATENCY (RL),
        .DEPTH        (DEPTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int passed = 0;
    int overflow_hits = 0;

    // Solver model: data requested in the accept cycle returns RL cycles later.
    logic [3:0] req_data;
    logic [3:0] sol_d [RL];
    always @(posedge clock) begin
        sol_d[0] <= req_data;
        for (int i = 1; i < RL; i++) sol_d[i] <= sol_d[i-1];
    end
    assign bus.rd_data = sol_d[RL-1];

    always @(posedge clock) begin
        if (!reset && dut.u_fifo.push && dut.u_fifo.full && !dut.u_fifo.pop)
            overflow_hits <= overflow_hits + 1;
    end

    function automatic logic [7:0] exp_map(input logic [3:0] d);
`ifdef PIXEL_PALETTE_EN
        case (d)
            4'h0: return 8'h00;  4'h1: return 8'h02;  4'h2: return 8'h10;  4'h3: return 8'h12;
            4'h4: return 8'h80;  4'h5: return 8'h82;  4'h6: return 8'h90;  4'h7: return 8'hB6;
            4'h8: return 8'h49;  4'h9: return 8'h03;  4'hA: return 8'h1C;  4'hB: return 8'h1F;
            4'hC: return 8'hE0;  4'hD: return 8'hE3;  4'hE: return 8'hFC;  default: return 8'hFF;
        endcase
`else
        return {d, d};
`endif
    endfunction

    function automatic logic [3:0] pix_fn(input int a);
        return 4'(a ^ (a >> 5) ^ (a >> 9));
    endfunction

    task automatic drive_in(input logic v, input logic s, input logic e, input logic [3:0] d);
        bus.in_valid = v;
        bus.in_start = s;
        bus.in_end   = e;
        req_data     = d;
    endtask

    task automatic test_reset();
        @(negedge clock);
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid); else passed++;
        checks++; if (bus.out_start !== 1'b0) $display("FAIL reset_out_start got %b want 0", bus.out_start); else passed++;
        checks++; if (bus.out_end !== 1'b0) $display("FAIL reset_out_end got %b want 0", bus.out_end); else passed++;
        checks++; if (bus.out_data !== 8'h00) $display("FAIL reset_out_data got %h want 00", bus.out_data); else passed++;
        checks++; if (bus.framing_err !== 1'b0) $display("FAIL reset_framing_err got %b want 0", bus.framing_err); else passed++;
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus.in_ready); else passed++;
        @(posedge clock); #1;
        reset = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_four_pixel_frame();
        logic [3:0] vals [4];
        vals[0] = 4'h1; vals[1] = 4'h2; vals[2] = 4'h3; vals[3] = 4'hF;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            if (k < 4) drive_in(1'b1, k == 0, k == 3, vals[k]);
            else       drive_in(1'b0, 1'b0, 1'b0, 4'h0);
            @(negedge clock);
            checks++; if (bus.out_valid !== (k >= 3 && k <= 6)) $display("FAIL frame_valid k=%0d got %b", k, bus.out_valid); else passed++;
            if (k >= 3 && k <= 6) begin
                checks++; if (bus.out_data !== exp_map(vals[k-3])) $display("FAIL frame_data k=%0d got %h want %h", k, bus.out_data, exp_map(vals[k-3])); else passed++;
                checks++; if (bus.out_start !== (k == 3)) $display("FAIL frame_start k=%0d got %b", k, bus.out_start); else passed++;
                checks++; if (bus.out_end !== (k == 6)) $display("FAIL frame_end k=%0d got %b", k, bus.out_end); else passed++;
            end
            if (k < 4) begin
                checks++; if (bus.in_ready !== 1'b1) $display("FAIL frame_in_ready k=%0d got %b want 1", k, bus.in_ready); else passed++;
            end
            @(posedge clock); #1;
        end
        checks++; if (bus.framing_err !== 1'b0) $display("FAIL frame_err got %b want 0", bus.framing_err); else passed++;
        $display("test_four_pixel_frame done");
    endtask

    task automatic test_edge_values();
        logic [3:0] vals [2];
        vals[0] = 4'hF; vals[1] = 4'h0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            if (k < 2) drive_in(1'b1, k == 0, k == 1, vals[k]);
            else       drive_in(1'b0, 1'b0, 1'b0, 4'h0);
            @(negedge clock);
            checks++; if (bus.out_valid !== (k == 3 || k == 4)) $display("FAIL edge_valid k=%0d got %b", k, bus.out_valid); else passed++;
            if (k == 3 || k == 4) begin
                checks++; if (bus.out_data !== exp_map(vals[k-3])) $display("FAIL edge_data k=%0d got %h want %h", k, bus.out_data, exp_map(vals[k-3])); else passed++;
            end
            @(posedge clock); #1;
        end
        $display("test_edge_values done");
    endtask

    task automatic test_backpressure();
        int idx = 0;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 14; k++) begin
            drive_in(1'b1, idx == 0, idx == 7, 4'(idx + 1));
            @(negedge clock);
            checks++; if (bus.in_ready !== (k < 8)) $display("FAIL bp_in_ready k=%0d got %b want %b", k, bus.in_ready, k < 8); else passed++;
            if (bus.in_ready) idx++;
            @(posedge clock); #1;
        end
        drive_in(1'b0, 1'b0, 1'b0, 4'h0);
        @(negedge clock);
        checks++; if (idx !== 8) $display("FAIL bp_accepts got %0d want 8", idx); else passed++;
        checks++; if (bus.out_valid !== 1'b1) $display("FAIL bp_hold_valid got %b want 1", bus.out_valid); else passed++;
        checks++; if (bus.out_data !== exp_map(4'h1)) $display("FAIL bp_hold_data got %h want %h", bus.out_data, exp_map(4'h1)); else passed++;
        @(posedge clock); #1;
        bus.out_ready = 1'b1;
        for (int b = 0; b < 8; b++) begin
            @(negedge clock);
            checks++; if (bus.out_valid !== 1'b1) $display("FAIL bp_drain_valid b=%0d got %b", b, bus.out_valid); else passed++;
            checks++; if (bus.out_data !== exp_map(4'(b + 1))) $display("FAIL bp_drain_data b=%0d got %h want %h", b, bus.out_data, exp_map(4'(b + 1))); else passed++;
            checks++; if (bus.out_start !== (b == 0) || bus.out_end !== (b == 7)) $display("FAIL bp_drain_flags b=%0d got %b%b", b, bus.out_start, bus.out_end); else passed++;
            if (b == 0) begin
                checks++; if (bus.in_ready !== 1'b0) $display("FAIL bp_ready_first_pop got %b want 0", bus.in_ready); else passed++;
            end
            if (b == 1) begin
                checks++; if (bus.in_ready !== 1'b1) $display("FAIL bp_ready_after_pop got %b want 1", bus.in_ready); else passed++;
            end
            @(posedge clock); #1;
        end
        @(negedge clock);
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL bp_drained got %b want 0", bus.out_valid); else passed++;
        @(posedge clock); #1;
        $display("test_backpressure done");
    endtask

    task automatic test_random_frame();
        int rx = 0, sop_cnt = 0, eop_cnt = 0, data_err = 0, flag_err = 0;
        fork
            begin
                int p = 0, guard = 0;
                logic acc;
                while (p < NPIX && guard < LIMIT) begin
                    drive_in(1'b1, p == 0, p == NPIX - 1, pix_fn(p));
                    @(negedge clock);
                    acc = bus.in_ready;
                    @(posedge clock); #1;
                    if (acc) p++;
                    guard++;
                end
                drive_in(1'b0, 1'b0, 1'b0, 4'h0);
            end
            begin
                int guard = 0;
                while (rx < NPIX && guard < LIMIT) begin
                    bus.out_ready = 1'($urandom_range(0, 1));
                    @(negedge clock);
                    if (bus.out_valid && bus.out_ready) begin
                        if (bus.out_data !== exp_map(pix_fn(rx))) data_err++;
                        if (bus.out_start !== (rx == 0) || bus.out_end !== (rx == NPIX - 1)) flag_err++;
                        if (bus.out_start) sop_cnt++;
                        if (bus.out_end) eop_cnt++;
                        rx++;
                    end
                    @(posedge clock); #1;
                    guard++;
                end
            end
        join
        bus.out_ready = 1'b1;
        @(negedge clock);
        checks++; if (rx !== NPIX) $display("FAIL rand_count got %0d want %0d", rx, NPIX); else passed++;
        checks++; if (data_err !== 0) $display("FAIL rand_order got %0d bad beats want 0", data_err); else passed++;
        checks++; if (flag_err !== 0) $display("FAIL rand_flags got %0d bad beats want 0", flag_err); else passed++;
        checks++; if (sop_cnt !== 1) $display("FAIL rand_sop_count got %0d want 1", sop_cnt); else passed++;
        checks++; if (eop_cnt !== 1) $display("FAIL rand_eop_count got %0d want 1", eop_cnt); else passed++;
        checks++; if (overflow_hits !== 0) $display("FAIL rand_overflow got %0d want 0", overflow_hits); else passed++;
        checks++; if (bus.framing_err !== 1'b0) $display("FAIL rand_framing_err got %b want 0", bus.framing_err); else passed++;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL rand_empty got %b want 0", bus.out_valid); else passed++;
        @(posedge clock); #1;
        $display("test_random_frame done");
    endtask

    task automatic test_framing_err();
        reset = 1'b1;
        drive_in(1'b0, 1'b0, 1'b0, 4'h0);
        @(posedge clock); #1;
        reset = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k == 0) drive_in(1'b1, 1'b0, 1'b0, 4'h5);
            else        drive_in(1'b0, 1'b0, 1'b0, 4'h0);
            @(negedge clock);
            if (k == 3) begin
                checks++; if (bus.out_valid !== 1'b1) $display("FAIL ferr_beat_valid got %b want 1", bus.out_valid); else passed++;
                checks++; if (bus.framing_err !== 1'b0) $display("FAIL ferr_before_pop got %b want 0", bus.framing_err); else passed++;
            end
            if (k == 4) begin
                checks++; if (bus.framing_err !== 1'b1) $display("FAIL ferr_after_pop got %b want 1", bus.framing_err); else passed++;
            end
            @(posedge clock); #1;
        end
        for (int k = 0; k < 7; k++) begin
            if (k < 2) drive_in(1'b1, k == 0, k == 1, 4'(k + 6));
            else       drive_in(1'b0, 1'b0, 1'b0, 4'h0);
            @(posedge clock); #1;
        end
        @(negedge clock);
        checks++; if (bus.framing_err !== 1'b1) $display("FAIL ferr_sticky got %b want 1", bus.framing_err); else passed++;
        @(posedge clock); #1;
        $display("test_framing_err done");
    endtask

    task automatic test_reset_midframe();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 7; k++) begin
            drive_in(1'b1, k == 0, 1'b0, 4'(k + 1));
            @(posedge clock); #1;
        end
        drive_in(1'b0, 1'b0, 1'b0, 4'h0);
        @(negedge clock);
        checks++; if (dut.u_fifo.count !== 4'd5) $display("FAIL mid_fifo_count got %0d want 5", dut.u_fifo.count); else passed++;
        checks++; if (dut.inflight_count_reg !== 4'd2) $display("FAIL mid_inflight got %0d want 2", dut.inflight_count_reg); else passed++;
        #1 reset = 1'b1;
        @(negedge clock);
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL mid_rst_valid got %b want 0", bus.out_valid); else passed++;
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL mid_rst_in_ready got %b want 1", bus.in_ready); else passed++;
        checks++; if (bus.framing_err !== 1'b0) $display("FAIL mid_rst_err got %b want 0", bus.framing_err); else passed++;
        @(posedge clock); #1;
        reset = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) begin
            @(posedge clock); #1;
        end
        @(negedge clock);
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL mid_no_stale got %b want 0", bus.out_valid); else passed++;
        @(posedge clock); #1;
        for (int k = 0; k < 7; k++) begin
            if (k < 2) drive_in(1'b1, k == 0, k == 1, 4'(k + 9));
            else       drive_in(1'b0, 1'b0, 1'b0, 4'h0);
            @(negedge clock);
            checks++; if (bus.out_valid !== (k == 3 || k == 4)) $display("FAIL mid_new_valid k=%0d got %b", k, bus.out_valid); else passed++;
            if (k == 3 || k == 4) begin
                checks++; if (bus.out_data !== exp_map(4'(k + 6))) $display("FAIL mid_new_data k=%0d got %h want %h", k, bus.out_data, exp_map(4'(k + 6))); else passed++;
            end
            @(posedge clock); #1;
        end
        checks++; if (bus.framing_err !== 1'b0) $display("FAIL mid_new_err got %b want 0", bus.framing_err); else passed++;
        $display("test_reset_midframe done");
    endtask

    initial begin
        reset         = 1'b1;
        bus.out_ready = 1'b0;
        drive_in(1'b0, 1'b0, 1'b0, 4'h0);
        test_reset();
        test_four_pixel_frame();
        test_edge_values();
        test_backpressure();
        test_random_frame();
        test_framing_err();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
